// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - clocked serial pattern generator with repeat count
//
// Captures a WIDTH-bit pattern and a repeat count on start, then emits the
// pattern MSB-first on signal, each bit held DIV clocks, rpt+1 times back to
// back. All outputs are registered.
//
// Ports:
//   clock    system clock, all state updates on posedge
//   reset    synchronous active-high reset
//   start    request, accepted only when idle
//   pattern  bits to emit, bit WIDTH-1 first
//   rpt      extra repetitions (pattern plays rpt+1 times)
//   signal   serial output
//   busy     high while the pattern is being emitted
//   done     one-cycle pulse after the final bit
//   bit_idx  index of the bit currently on signal
module pattern_sequencer #(
  parameter int WIDTH = 11,
  parameter int DIV   = 4,
  parameter int RPT_W = 4,
  parameter int IDX_W = 4,
  parameter int DIV_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [RPT_W-1:0] rpt,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_idx
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [RPT_W-1:0] rpt_cnt;
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      signal  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_idx <= '0;
      div_cnt <= '0;
      rpt_cnt <= '0;
      shadow  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Emission reads only shadow, so later pattern changes are harmless.
            shadow  <= pattern;
            rpt_cnt <= rpt;
            signal  <= pattern[WIDTH-1];
            bit_idx <= IDX_LAST;
            div_cnt <= DIV_LAST;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            signal <= 1'b0;
            busy   <= 1'b0;
          end
        end

        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (bit_idx != '0) begin
            bit_idx <= bit_idx - 1'b1;
            signal  <= shadow[bit_idx - 1'b1];
            div_cnt <= DIV_LAST;
          end else if (rpt_cnt != '0) begin
            // Wrap straight into the next repetition with no idle gap.
            rpt_cnt <= rpt_cnt - 1'b1;
            bit_idx <= IDX_LAST;
            signal  <= shadow[WIDTH-1];
            div_cnt <= DIV_LAST;
          end else begin
            signal  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            bit_idx <= '0;
            state   <= DONE;
          end
        end

        DONE: begin
          // One-cycle cooldown: a start seen here is deliberately dropped.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

  localparam int W = 11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [10:0] pat0 = '0, pat1 = '0;
  logic [3:0]  rpt0 = '0, rpt1 = '0;
  logic        sig0, busy0, done0, sig1, busy1, done1;
  logic [3:0]  idx0, idx1;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pattern_sequencer #(.WIDTH(11), .DIV(4), .RPT_W(4), .IDX_W(4), .DIV_W(3)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .pattern(pat0), .rpt(rpt0),
    .signal(sig0), .busy(busy0), .done(done0), .bit_idx(idx0)
  );

  pattern_sequencer #(.WIDTH(11), .DIV(1), .RPT_W(4), .IDX_W(4), .DIV_W(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .pattern(pat1), .rpt(rpt1),
    .signal(sig1), .busy(busy1), .done(done1), .bit_idx(idx1)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input int which, input string tag,
                               input logic es, input logic eb, input logic ed, input int ei);
    if (which == 0) begin
      check({tag, "/signal0"}, 32'(sig0), 32'(es));
      check({tag, "/busy0"}, 32'(busy0), 32'(eb));
      check({tag, "/done0"}, 32'(done0), 32'(ed));
      check({tag, "/bit_idx0"}, 32'(idx0), 32'(ei));
    end else begin
      check({tag, "/signal1"}, 32'(sig1), 32'(es));
      check({tag, "/busy1"}, 32'(busy1), 32'(eb));
      check({tag, "/done1"}, 32'(done1), 32'(ed));
      check({tag, "/bit_idx1"}, 32'(idx1), 32'(ei));
    end
  endtask

  task automatic drive(input int which, input logic s, input logic [10:0] p, input logic [3:0] r);
    if (which == 0) begin
      start0 = s; pat0 = p; rpt0 = r;
    end else begin
      start1 = s; pat1 = p; rpt1 = r;
    end
  endtask

  // Plays one accepted request and compares every cycle against the timeline:
  // output slot n = t/div carries bit W-1-(n mod W) until T=(rpt+1)*W*div,
  // then a single done cycle, then idle. noisy scrambles start/pattern/rpt
  // while busy and asserts start in the DONE cycle. reset_at>=0 resets the
  // DUT at that edge offset and checks it stays quiet afterwards.
  task automatic run_pass(input int which, input string tag, input logic [10:0] pat,
                          input logic [3:0] r, input bit noisy, input int reset_at);
    int div;
    int total;
    int idx;
    div   = (which == 0) ? 4 : 1;
    total = (int'(r) + 1) * W * div;
    drive(which, 1'b1, pat, r);
    for (int t = 0; t <= total + 1; t++) begin
      @(negedge clock);
      if (reset_at >= 0 && t == reset_at) begin
        check_outputs(which, {tag, "/reset_mid"}, 1'b0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        for (int q = 0; q < 6; q++) begin
          @(negedge clock);
          check_outputs(which, {tag, "/post_reset"}, 1'b0, 1'b0, 1'b0, 0);
        end
        return;
      end
      if (t < total) begin
        idx = W - 1 - ((t / div) % W);
        check_outputs(which, tag, pat[idx], 1'b1, 1'b0, idx);
      end else if (t == total) begin
        check_outputs(which, {tag, "/done"}, 1'b0, 1'b0, 1'b1, 0);
      end else begin
        check_outputs(which, {tag, "/after"}, 1'b0, 1'b0, 1'b0, 0);
      end
      if (reset_at >= 0 && t + 1 == reset_at) begin
        reset = 1'b1;
        drive(which, 1'b0, '0, '0);
      end else if (noisy && t < total) begin
        drive(which, 1'($urandom), 11'($urandom), 4'($urandom));
      end else if (noisy && t == total) begin
        drive(which, 1'b1, 11'($urandom), 4'($urandom));
      end else begin
        drive(which, 1'b0, '0, '0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_outputs(0, "reset", 1'b0, 1'b0, 1'b0, 0);
    check_outputs(1, "reset", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_outputs(0, "idle", 1'b0, 1'b0, 1'b0, 0);
      check_outputs(1, "idle", 1'b0, 1'b0, 1'b0, 0);
    end

    run_pass(0, "single", 11'b10101001010, 4'd0, 1'b0, -1);
    run_pass(0, "repeat_shadow", 11'b11110000111, 4'd2, 1'b1, -1);
    run_pass(0, "start_ignored", 11'b10101001010, 4'd0, 1'b1, -1);
    run_pass(0, "back_to_back", 11'b10101001010, 4'd0, 1'b0, -1);
    run_pass(0, "reset_mid", 11'b01100111010, 4'd0, 1'b0, 17);
    run_pass(1, "div1", 11'b10000000001, 4'd0, 1'b0, -1);
    run_pass(1, "div1_rpt_max", 11'b11001010011, 4'd15, 1'b1, -1);

    for (int i = 0; i < 4; i++)
      run_pass(0, "rand_div4", 11'($urandom), 4'($urandom_range(0, 2)), 1'b1, -1);
    for (int i = 0; i < 4; i++)
      run_pass(1, "rand_div1", 11'($urandom), 4'($urandom_range(0, 5)), 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
